tick_sched: RTL and testbench
=============================

TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter DIVISOR, default 50_000_000: prescaler period in clk cycles (>=2).
REQ-002 Parameter NUM_CH, default 4: number of timer channels (2..16).
REQ-003 Parameter CNT_W, default 16: channel period/counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  configuration write strobe, one cycle per write.
REQ-007 cfg_ch  in  CH_W=max(1,clog2(NUM_CH))  target channel of the write.
REQ-008 cfg_period  in  CNT_W  period in prescaler ticks.
REQ-009 cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
REQ-010 cfg_en  in  1  channel enable.
REQ-011 tick  out  1  one-cycle prescaler pulse.
REQ-012 evt_valid  out  1  expiry event offered.
REQ-013 evt_ch  out  CH_W  channel of the offered event.
REQ-014 evt_ready  in  1  consumer accepts the event.
REQ-015 active  out  NUM_CH  per-channel enabled flag.
REQ-016 overrun  out  NUM_CH  sticky per-channel lost-event flag.

Function
REQ-017 Prescaler counts 0..DIVISOR-1 and wraps to 0; tick=1 exactly when the count equals DIVISOR-1, giving one pulse every DIVISOR cycles.
REQ-018 Per-channel state: en, oneshot, period, cnt, pending.
REQ-019 cfg_we: load period, oneshot, en=cfg_en&(cfg_period!=0), set cnt=cfg_period, clear overrun[cfg_ch]; pending is not modified.
REQ-020 On tick, each enabled channel with cnt>1 decrements cnt; a channel with cnt==1 expires.
REQ-021 Expiry: cnt reloads to period, pending set; oneshot channels clear en.
REQ-022 Expiry while pending already set (and not being accepted that cycle): overrun set, pending stays single.
REQ-023 cfg_we and tick in the same cycle on the same channel: configuration wins and the tick is ignored for that channel; other channels tick normally.
REQ-024 Handshake (evt_valid&evt_ready) clears pending[evt_ch]; a simultaneous expiry of the same channel leaves pending set without setting overrun.
REQ-025 Arbiter: round-robin over pending channels starting at pointer rr; after a handshake, rr=evt_ch+1 modulo NUM_CH.
REQ-026 evt_valid/evt_ch registered; the earliest assertion is the cycle after pending becomes visible, i.e. 2 cycles after the expiring tick.
REQ-027 While evt_valid=1 and evt_ready=0, evt_valid and evt_ch hold stable; no re-arbitration.
REQ-028 After a handshake, evt_valid may reassert on the next cycle for another pending channel; one handshake per cycle maximum.
REQ-029 active mirrors en; overrun clears only on reset or cfg_we to that channel.

Reset
REQ-030 rst asynchronously forces the prescaler to 0, all en/oneshot/period/cnt/pending/overrun to 0, rr to 0, tick=0, evt_valid=0, evt_ch=0.
REQ-031 Reset asserted mid-handshake drops evt_valid immediately; the event is lost.

Structure
REQ-032 Shared package tick_sched_pkg holds the NUM_CH and CNT_W defaults, the CH_W derivation and the channel-state record typedef.
REQ-033 The prescaler is the sub-module tick_gen (DIVISOR parameter, clk/rst, one-cycle tick output); all other logic is in tick_sched.

Verification (DIVISOR=4, NUM_CH=4, CNT_W=8)
REQ-034 Write ch0 period=3, periodic, evt_ready=1 -> evt_valid with evt_ch=0 every 12 cycles, the first one 2 cycles after the third tick.
REQ-035 Write ch1 period=2, oneshot -> exactly one event on ch1, after which active[1]=0 and no further events occur.
REQ-036 ch0 and ch2 both period=1, evt_ready=0 for 6 ticks -> overrun[0]=overrun[2]=1; then evt_ready=1 -> events ch0 then ch2, in that order, once each.
REQ-037 Channels 0..3 all period=1 with evt_ready=1 -> event order 0,1,2,3 with no starvation; evt_ch stable during every ready=0 stall.
REQ-038 cfg_we to ch0 on the tick cycle where cnt==1 -> no expiry that tick; cnt=new period.
REQ-039 Assert rst while evt_valid=1 -> all outputs 0 in the same cycle; after release, the first tick occurs 4 cycles later.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: parameter defaults, channel-index
// width derivation and the per-channel flag record.
package tick_sched_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    // Channel index width: at least one bit even for degenerate channel counts.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Single-bit state kept per channel; period/count live in separate arrays
    // because their width is a module parameter.
    typedef struct packed {
        logic en;
        logic oneshot;
        logic pending;
        logic overrun;
    } ch_flags_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIVISOR-1 and pulses tick for one cycle while the
// count equals DIVISOR-1.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : registered one-cycle pulse every DIVISOR cycles
module tick_gen #(
    parameter int unsigned DIVISOR = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    // tick_q is computed from the next count so it is high exactly while the
    // registered count sits at DIVISOR-1.
    always_comb begin
        pre_d  = (pre_q == PW'(DIVISOR - 1)) ? '0 : pre_q + PW'(1);
        tick_d = (pre_d == PW'(DIVISOR - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: per-channel periodic/one-shot timers clocked by
// a shared prescaler, with a round-robin valid/ready event output.
//   cfg_we/cfg_ch/cfg_period/cfg_oneshot/cfg_en : channel configuration write
//   tick                 : prescaler pulse
//   evt_valid/evt_ch     : offered expiry event, held until evt_ready
//   active               : per-channel enable
//   overrun              : sticky per-channel lost-event flag
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int unsigned  DIVISOR = 50_000_000,
    parameter int unsigned  NUM_CH  = NUM_CH_DEF,
    parameter int unsigned  CNT_W   = CNT_W_DEF,
    localparam int unsigned CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic              cfg_en,
    output logic              tick,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] overrun
);

    ch_flags_t [NUM_CH-1:0] flg_q, flg_d;
    logic [CNT_W-1:0]       period_q [NUM_CH];
    logic [CNT_W-1:0]       period_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q    [NUM_CH];
    logic [CNT_W-1:0]       cnt_d    [NUM_CH];
    logic                   evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]        evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]        rr_q, rr_d;

    logic                   hs_c;
    logic                   hit, hs_ch, expire;
    logic [NUM_CH-1:0]      cand;
    logic [CH_W-1:0]        start;
    logic                   found;
    int                     idx;

    tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign hs_c = evt_valid_q & evt_ready;

    // Channel timers: a config write overrides any tick on the same channel.
    always_comb begin
        flg_d    = flg_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        hit      = 1'b0;
        hs_ch    = 1'b0;
        expire   = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit    = cfg_we && (cfg_ch == CH_W'(i));
            hs_ch  = hs_c && (evt_ch_q == CH_W'(i));
            expire = 1'b0;
            if (hit) begin
                period_d[i]       = cfg_period;
                cnt_d[i]          = cfg_period;
                flg_d[i].oneshot  = cfg_oneshot;
                flg_d[i].en       = cfg_en & (cfg_period != '0);
                flg_d[i].overrun  = 1'b0;
            end else if (tick && flg_q[i].en && (cnt_q[i] != '0)) begin
                if (cnt_q[i] == CNT_W'(1)) begin
                    expire = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            // An expiry racing the acceptance of the same channel re-arms
            // pending without counting as a lost event.
            if (expire) begin
                cnt_d[i]         = period_q[i];
                flg_d[i].pending = 1'b1;
                if (flg_q[i].oneshot) flg_d[i].en = 1'b0;
                if (flg_q[i].pending && !hs_ch) flg_d[i].overrun = 1'b1;
            end else if (hs_ch) begin
                flg_d[i].pending = 1'b0;
            end
        end
    end

    // Round-robin arbiter; the offer is frozen while the consumer stalls.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_d        = rr_q;
        start       = rr_q;
        found       = 1'b0;
        idx         = 0;
        for (int i = 0; i < int'(NUM_CH); i++) cand[i] = flg_q[i].pending;
        if (hs_c) begin
            rr_d           = (evt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
            start          = rr_d;
            cand[evt_ch_q] = 1'b0;
        end
        if (!evt_valid_q || evt_ready) begin
            evt_valid_d = 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                idx = int'(start) + k;
                if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
                if (!found && cand[idx]) begin
                    found       = 1'b1;
                    evt_valid_d = 1'b1;
                    evt_ch_d    = CH_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_q        <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            flg_q       <= flg_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_q        <= rr_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            active[i]  = flg_q[i].en;
            overrun[i] = flg_q[i].overrun;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched (DIVISOR=4, NUM_CH=4, CNT_W=8).
// Inputs change 1 time unit after each rising edge; the reference model and
// the event monitor both sample on the falling edge.
module tb_tick_sched;

    localparam int DIV = 4;
    localparam int N   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0;
    logic       cfg_oneshot = 1'b0;
    logic       cfg_en = 1'b0;
    logic       tick;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_ready = 1'b0;
    logic [3:0] active;
    logic [3:0] overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // scoreboard: channels the model expects to be offered, in order
    int exp_q[$];
    int hs_log[$];
    int hs_cnt[N];
    int last_hs_cyc[N];

    // reference model state
    int  m_pres;
    bit  m_tick;
    bit  m_en[N], m_os[N], m_pend[N], m_ovr[N];
    int  m_per[N], m_cnt[N];
    int  m_rr;
    bit  m_valid;
    int  m_ch;

    tick_sched #(.DIVISOR(4), .NUM_CH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .cfg_en      (cfg_en),
        .tick        (tick),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready),
        .active      (active),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pres = 0; m_tick = 0; m_rr = 0; m_valid = 0; m_ch = 0;
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_os[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
            m_per[i] = 0; m_cnt[i] = 0;
        end
        exp_q.delete();
    endtask

    // Reference model: compare this cycle's outputs, then apply this cycle's
    // inputs to get the state seen after the next rising edge.
    initial begin : model
        bit op[N];
        bit hs, hsi, ex, found;
        int a, o, start, old_ch, idx;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                chk("rst_outputs", int'({tick, evt_valid, evt_ch, active, overrun}), 0);
                continue;
            end
            a = 0; o = 0;
            for (int i = 0; i < N; i++) begin
                if (m_en[i])  a |= (1 << i);
                if (m_ovr[i]) o |= (1 << i);
            end
            chk("tick", int'(tick), int'(m_tick));
            chk("evt_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) chk("evt_ch", int'(evt_ch), m_ch);
            chk("active", int'(active), a);
            chk("overrun", int'(overrun), o);

            hs = m_valid && evt_ready;
            old_ch = m_ch;
            for (int i = 0; i < N; i++) op[i] = m_pend[i];
            for (int i = 0; i < N; i++) begin
                hsi = hs && (old_ch == i);
                ex = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_per[i] = int'(cfg_period);
                    m_cnt[i] = int'(cfg_period);
                    m_os[i]  = cfg_oneshot;
                    m_en[i]  = cfg_en && (cfg_period != 0);
                    m_ovr[i] = 0;
                end else if (m_tick && m_en[i]) begin
                    if (m_cnt[i] > 1) m_cnt[i]--;
                    else ex = 1;
                end
                if (ex) begin
                    m_cnt[i] = m_per[i];
                    if (m_os[i]) m_en[i] = 0;
                    if (m_pend[i] && !hsi) m_ovr[i] = 1;
                    m_pend[i] = 1;
                end else if (hsi) begin
                    m_pend[i] = 0;
                end
            end
            if (!(m_valid && !evt_ready)) begin
                if (hs) m_rr = (old_ch + 1) % N;
                start = m_rr;
                m_valid = 0;
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (start + k) % N;
                    if (!found && op[idx] && !(hs && idx == old_ch)) begin
                        found = 1;
                        m_valid = 1;
                        m_ch = idx;
                        exp_q.push_back(idx);
                    end
                end
            end
            m_pres = (m_pres + 1) % DIV;
            m_tick = (m_pres == DIV - 1);
        end
    end

    // Monitor: every accepted event must be the next one the model predicted.
    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (!rst && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", int'(evt_ch), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_ch_sb", int'(evt_ch), e);
                end
                hs_log.push_back(int'(evt_ch));
                hs_cnt[evt_ch]++;
                last_hs_cyc[evt_ch] = cyc;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int per, input bit os, input bit en);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 8'(per); cfg_oneshot = os; cfg_en = en;
        step(1);
        cfg_we = 0;
    endtask

    task automatic wait_hs(input int ch, input int budget, output int at);
        int c0;
        c0 = hs_cnt[ch];
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt[ch] != c0) break;
            step(1);
        end
        if (hs_cnt[ch] == c0) chk("wait_hs_timeout", ch, -1);
        else at = last_hs_cyc[ch];
    endtask

    task automatic wait_tick(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tick) break;
            step(1);
        end
        if (!tick) chk("wait_tick_timeout", 0, 1);
    endtask

    initial begin : stim
        int t1, t2, t3, n0, n2, lg, tw, n;
        step(3);
        rst = 0;

        // periodic channel 0, period 3 ticks
        evt_ready = 1;
        cfg(0, 3, 0, 1);
        wait_hs(0, 100, t1);
        wait_hs(0, 100, t2);
        wait_hs(0, 100, t3);
        chk("ch0_interval_a", t2 - t1, 12);
        chk("ch0_interval_b", t3 - t2, 12);
        cfg(0, 0, 0, 0);
        step(12);

        // one-shot channel 1
        n0 = hs_cnt[1];
        cfg(1, 2, 1, 1);
        wait_hs(1, 60, t1);
        step(40);
        chk("ch1_oneshot_count", hs_cnt[1] - n0, 1);
        chk("ch1_inactive", int'(active[1]), 0);

        // overrun on ch0 and ch2 while the consumer stalls
        evt_ready = 0;
        cfg(0, 1, 0, 1);
        cfg(2, 1, 0, 1);
        step(6 * DIV);
        chk("ovr0", int'(overrun[0]), 1);
        chk("ovr2", int'(overrun[2]), 1);
        chk("stall_ch", int'(evt_ch), 0);
        cfg(0, 0, 0, 0);
        cfg(2, 0, 0, 0);
        n0 = hs_cnt[0]; n2 = hs_cnt[2]; lg = hs_log.size();
        evt_ready = 1;
        step(10);
        chk("drain_ch0_once", hs_cnt[0] - n0, 1);
        chk("drain_ch2_once", hs_cnt[2] - n2, 1);
        chk("drain_count", hs_log.size() - lg, 2);
        if (hs_log.size() - lg == 2) begin
            chk("drain_first", hs_log[lg], 0);
            chk("drain_second", hs_log[lg + 1], 2);
        end

        // all channels period 1 with a stuttering consumer
        for (int i = 0; i < N; i++) cfg(i, 1, 0, 1);
        for (int i = 0; i < 80; i++) begin
            evt_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        evt_ready = 1;
        step(8);
        lg = hs_log.size();
        if (lg >= 9) begin
            for (int i = lg - 8; i < lg; i++)
                chk("rr_rotation", hs_log[i], (hs_log[i - 1] + 1) % N);
        end else begin
            chk("rr_enough_events", lg, 9);
        end
        for (int i = 0; i < N; i++) cfg(i, 0, 0, 0);
        step(12);

        // config write on the expiring tick wins over the tick
        cfg(0, 1, 0, 1);
        step(10);
        wait_tick(8);
        tw = cyc;
        n0 = hs_cnt[0];
        cfg(0, 3, 0, 1);
        step(8);
        chk("cfg_beats_tick", hs_cnt[0] - n0, 0);
        wait_hs(0, 30, t1);
        chk("cfg_reload_latency", t1 - tw, 14);
        cfg(0, 0, 0, 0);
        step(8);

        // reset while an event is on offer
        evt_ready = 0;
        cfg(1, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (evt_valid) break;
            step(1);
        end
        chk("pre_rst_valid", int'(evt_valid), 1);
        rst = 1;
        #1;
        chk("rst_drops_valid", int'(evt_valid), 0);
        chk("rst_clears_active", int'(active), 0);
        step(2);
        rst = 0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            if (tick) break;
            step(1);
            n++;
        end
        chk("first_tick_cycle_after_rst", n, 4);

        // randomized configuration and back-pressure
        for (int i = 0; i < 2000; i++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            if (cfg_we) begin
                cfg_ch      = 2'($urandom_range(0, 3));
                cfg_period  = 8'($urandom_range(0, 5));
                cfg_oneshot = 1'($urandom_range(0, 1));
                cfg_en      = ($urandom_range(0, 3) != 0);
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        cfg_we = 0;
        for (int i = 0; i < N; i++) cfg(i, 0, 0, 0);
        evt_ready = 1;
        step(30);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
